// File: rtl/dio_slot_bank.sv
// dio_slot_bank: a bank of SLOTS digital I/O slots. Each slot has DATA_W pins
// and a set of DATA_W-wide registers on a simple single-cycle strobe bus.
//
// Register map: address = type*SLOTS + slot
//   0 OUT        pad output values (slot_o)
//   1 IN         synchronised pad inputs (read-only)
//   2 DIR        per-pin output enable (slot_oe), 1 = drive
//   3 INT_STATUS sticky edge flags (read-only)
//   4 INT_MASK   gates INT_STATUS onto irq
//   5 INT_CLEAR  write 1 to clear INT_STATUS bits (write-only, reads 0)
//   6 INT_RISE   enable rising-edge capture
//   7 INT_FALL   enable falling-edge capture
// Any address >= 8*SLOTS is acknowledged, reads 0 and ignores writes.
//
// Ports:
//   sys_clk, sys_rst_n      clock, asynchronous active-low reset
//   bus_stb, bus_we         one-cycle access request, 1 = write
//   bus_addr, bus_wdata     access address and write data
//   bus_rdata, bus_ack      registered read data and completion, one cycle later
//   slot_i                  pad inputs, slot s at [s*DATA_W +: DATA_W]
//   slot_o, slot_oe         pad output values and output enables
//   irq                     registered OR of INT_STATUS & INT_MASK over all slots
module dio_slot_bank #(
  parameter int SLOTS       = 1,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    bus_stb,
  input  logic                    bus_we,
  input  logic [ADDR_W-1:0]       bus_addr,
  input  logic [DATA_W-1:0]       bus_wdata,
  output logic [DATA_W-1:0]       bus_rdata,
  output logic                    bus_ack,
  input  logic [SLOTS*DATA_W-1:0] slot_i,
  output logic [SLOTS*DATA_W-1:0] slot_o,
  output logic [SLOTS*DATA_W-1:0] slot_oe,
  output logic                    irq
);

  localparam int NB      = SLOTS * DATA_W;
  localparam int SW      = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int AW      = $clog2(ARM_MAX + 1);

  logic [NB-1:0]     out_r;
  logic [NB-1:0]     dir_r;
  logic [NB-1:0]     mask_r;
  logic [NB-1:0]     status_r;
  logic [NB-1:0]     rise_r;
  logic [NB-1:0]     fall_r;
  logic [NB-1:0]     sync_r [SYNC_STAGES];
  logic [NB-1:0]     dly_r;
  logic [AW-1:0]     arm_cnt_r;
  logic [DATA_W-1:0] rdata_r;
  logic              ack_r;
  logic              irq_r;

  logic              hit_s;
  logic [2:0]        sel_type_s;
  logic [SW-1:0]     sel_slot_s;
  logic              wr_s;
  logic [DATA_W-1:0] rd_s;
  logic [NB-1:0]     sync_out_s;
  logic [NB-1:0]     rise_ev_s;
  logic [NB-1:0]     fall_ev_s;
  logic              armed_s;
  logic [NB-1:0]     set_s;
  logic [NB-1:0]     clr_s;
  logic [NB-1:0]     status_nx_s;

  assign slot_o    = out_r;
  assign slot_oe   = dir_r;
  assign bus_rdata = rdata_r;
  assign bus_ack   = ack_r;
  assign irq       = irq_r;

  assign sync_out_s = sync_r[SYNC_STAGES-1];
  assign rise_ev_s  = sync_out_s & ~dly_r;
  assign fall_ev_s  = ~sync_out_s & dly_r;
  assign armed_s    = (arm_cnt_r == AW'(ARM_MAX));
  assign wr_s       = bus_stb & bus_we & hit_s;

  // Address decode: match against every legal type/slot pair so that
  // non-power-of-two SLOTS needs no divider.
  always_comb begin
    hit_s      = 1'b0;
    sel_type_s = 3'd0;
    sel_slot_s = {SW{1'b0}};
    for (int t = 0; t < 8; t++) begin
      for (int s = 0; s < SLOTS; s++) begin
        hit_s      = hit_s | (bus_addr == ADDR_W'(t * SLOTS + s));
        sel_type_s = (bus_addr == ADDR_W'(t * SLOTS + s)) ? 3'(t) : sel_type_s;
        sel_slot_s = (bus_addr == ADDR_W'(t * SLOTS + s)) ? SW'(s) : sel_slot_s;
      end
    end
  end

  // Read multiplexer over the selected slot's registers.
  always_comb begin
    int base;
    base = int'(sel_slot_s) * DATA_W;
    rd_s = {DATA_W{1'b0}};
    if (hit_s) begin
      case (sel_type_s)
        3'd0:    rd_s = out_r[base +: DATA_W];
        3'd1:    rd_s = sync_out_s[base +: DATA_W];
        3'd2:    rd_s = dir_r[base +: DATA_W];
        3'd3:    rd_s = status_r[base +: DATA_W];
        3'd4:    rd_s = mask_r[base +: DATA_W];
        3'd6:    rd_s = rise_r[base +: DATA_W];
        3'd7:    rd_s = fall_r[base +: DATA_W];
        default: rd_s = {DATA_W{1'b0}};
      endcase
    end else begin
      rd_s = {DATA_W{1'b0}};
    end
  end

  // Interrupt status next state: edge set wins over a simultaneous clear.
  always_comb begin
    clr_s = {NB{1'b0}};
    for (int s = 0; s < SLOTS; s++) begin
      clr_s[s*DATA_W +: DATA_W] =
        (wr_s && (sel_type_s == 3'd5) && (sel_slot_s == SW'(s))) ? bus_wdata : {DATA_W{1'b0}};
    end
    set_s       = armed_s ? ((rise_ev_s & rise_r) | (fall_ev_s & fall_r)) : {NB{1'b0}};
    status_nx_s = (status_r & ~clr_s) | set_s;
  end

  // Register file writes and sticky status update.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_r    <= {NB{1'b0}};
      dir_r    <= {NB{1'b0}};
      mask_r   <= {NB{1'b0}};
      status_r <= {NB{1'b0}};
      rise_r   <= {NB{1'b1}};
      fall_r   <= {NB{1'b0}};
    end else begin
      status_r <= status_nx_s;
      for (int s = 0; s < SLOTS; s++) begin
        if (wr_s && (sel_slot_s == SW'(s))) begin
          case (sel_type_s)
            3'd0:    out_r[s*DATA_W +: DATA_W]  <= bus_wdata;
            3'd2:    dir_r[s*DATA_W +: DATA_W]  <= bus_wdata;
            3'd4:    mask_r[s*DATA_W +: DATA_W] <= bus_wdata;
            3'd6:    rise_r[s*DATA_W +: DATA_W] <= bus_wdata;
            3'd7:    fall_r[s*DATA_W +: DATA_W] <= bus_wdata;
            default: ;
          endcase
        end
      end
    end
  end

  // Input synchroniser chain plus the one-cycle delayed copy for edge detection.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= {NB{1'b0}};
      end
      dly_r <= {NB{1'b0}};
    end else begin
      sync_r[0] <= slot_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      dly_r <= sync_out_s;
    end
  end

  // Arm counter: edge detection stays off until the synchroniser and delay
  // stage hold post-reset pad levels, so static pads never look like edges.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      arm_cnt_r <= {AW{1'b0}};
    end else if (!armed_s) begin
      arm_cnt_r <= arm_cnt_r + AW'(1);
    end else begin
      arm_cnt_r <= arm_cnt_r;
    end
  end

  // Bus response and interrupt output registers; read data holds across writes.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ack_r   <= 1'b0;
      rdata_r <= {DATA_W{1'b0}};
      irq_r   <= 1'b0;
    end else begin
      ack_r <= bus_stb;
      if (bus_stb && !bus_we) begin
        rdata_r <= rd_s;
      end else begin
        rdata_r <= rdata_r;
      end
      irq_r <= |(status_r & mask_r);
    end
  end

endmodule

// File: tb/tb_dio_slot_bank.sv
// Self-checking bench for dio_slot_bank (SLOTS=2, DATA_W=16, SYNC_STAGES=2).
// A register-level reference model (per-type arrays, pad sample history)
// predicts every output and is compared on each falling clock edge; directed
// scenarios add constant checks for the documented corner cases, followed by
// a randomised phase.
module tb_dio_slot_bank;

  localparam int SLOTS = 2;
  localparam int DW    = 16;
  localparam int SS    = 2;
  localparam int NB    = SLOTS * DW;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          bus_stb   = 1'b0;
  logic          bus_we    = 1'b0;
  logic [7:0]    bus_addr  = 8'd0;
  logic [DW-1:0] bus_wdata = 16'd0;
  logic [DW-1:0] bus_rdata;
  logic          bus_ack;
  logic [NB-1:0] slot_i    = {NB{1'b1}};
  logic [NB-1:0] slot_o;
  logic [NB-1:0] slot_oe;
  logic          irq;

  int n_cmp = 0;
  int n_err = 0;

  dio_slot_bank #(
    .SLOTS(SLOTS), .DATA_W(DW), .ADDR_W(8), .SYNC_STAGES(SS)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .slot_i(slot_i), .slot_o(slot_o), .slot_oe(slot_oe), .irq(irq)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] m_out  [SLOTS];
  logic [DW-1:0] m_dir  [SLOTS];
  logic [DW-1:0] m_mask [SLOTS];
  logic [DW-1:0] m_stat [SLOTS];
  logic [DW-1:0] m_rise [SLOTS];
  logic [DW-1:0] m_fall [SLOTS];
  logic [NB-1:0] smp    [SS+1];   // smp[j] = pad sample taken j+1 edges ago
  int            m_edges;         // clock edges since reset release (saturating)
  logic          e_ack;
  logic [DW-1:0] e_rdata;
  logic          e_irq;

  task automatic model_reset();
    for (int s = 0; s < SLOTS; s++) begin
      m_out[s] = 16'h0000; m_dir[s] = 16'h0000; m_mask[s] = 16'h0000;
      m_stat[s] = 16'h0000; m_rise[s] = 16'hFFFF; m_fall[s] = 16'h0000;
    end
    for (int j = 0; j <= SS; j++) smp[j] = {NB{1'b0}};
    m_edges = 0;
    e_ack = 1'b0;
    e_rdata = 16'h0000;
    e_irq = 1'b0;
  endtask

  function automatic logic [DW-1:0] reg_value(input int ty, input int sl);
    logic [NB-1:0] in_now;
    in_now = smp[SS-1];
    case (ty)
      0: return m_out[sl];
      1: return in_now[sl*DW +: DW];
      2: return m_dir[sl];
      3: return m_stat[sl];
      4: return m_mask[sl];
      6: return m_rise[sl];
      7: return m_fall[sl];
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_step();
    int ty;
    int sl;
    bit valid;
    logic [NB-1:0] cur_all;
    logic [NB-1:0] prv_all;
    logic [DW-1:0] cur;
    logic [DW-1:0] prv;
    logic [DW-1:0] setv;
    logic [DW-1:0] clrv;
    e_irq = 1'b0;
    for (int s = 0; s < SLOTS; s++) if ((m_stat[s] & m_mask[s]) != 16'h0000) e_irq = 1'b1;
    if (m_edges < SS + 2) m_edges++;
    valid = (int'(bus_addr) < 8 * SLOTS);
    ty = int'(bus_addr) / SLOTS;
    sl = int'(bus_addr) % SLOTS;
    e_ack = bus_stb;
    if (bus_stb && !bus_we) e_rdata = valid ? reg_value(ty, sl) : 16'h0000;
    cur_all = smp[SS-1];
    prv_all = smp[SS];
    for (int s = 0; s < SLOTS; s++) begin
      cur = cur_all[s*DW +: DW];
      prv = prv_all[s*DW +: DW];
      setv = (m_edges >= SS + 2) ? ((cur & ~prv & m_rise[s]) | (~cur & prv & m_fall[s])) : 16'h0000;
      clrv = (bus_stb && bus_we && valid && ty == 5 && sl == s) ? bus_wdata : 16'h0000;
      m_stat[s] = (m_stat[s] & ~clrv) | setv;
    end
    if (bus_stb && bus_we && valid) begin
      case (ty)
        0: m_out[sl]  = bus_wdata;
        2: m_dir[sl]  = bus_wdata;
        4: m_mask[sl] = bus_wdata;
        6: m_rise[sl] = bus_wdata;
        7: m_fall[sl] = bus_wdata;
        default: ;
      endcase
    end
    for (int j = SS; j >= 1; j--) smp[j] = smp[j-1];
    smp[0] = slot_i;
  endtask

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) model_reset();
    else model_step();
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge sys_clk) begin
    check_val("ack", {31'd0, bus_ack}, {31'd0, e_ack});
    check_val("rdata", {16'd0, bus_rdata}, {16'd0, e_rdata});
    check_val("slot_o", slot_o, {m_out[1], m_out[0]});
    check_val("slot_oe", slot_oe, {m_dir[1], m_dir[0]});
    check_val("irq", {31'd0, irq}, {31'd0, e_irq});
  end

  // ---------------- bus helpers (call on a falling edge) ----------------
  task automatic bus_wr(input logic [7:0] addr, input logic [DW-1:0] data);
    bus_stb = 1'b1; bus_we = 1'b1; bus_addr = addr; bus_wdata = data;
    @(negedge sys_clk);
    bus_stb = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] addr, output logic [DW-1:0] data);
    bus_stb = 1'b1; bus_we = 1'b0; bus_addr = addr;
    @(negedge sys_clk);
    bus_stb = 1'b0;
    data = bus_rdata;
    check_val("rd_ack", {31'd0, bus_ack}, 32'd1);
  endtask

  logic [DW-1:0] rd;

  initial begin
    // Reset with all pads high, then release: no spurious status.
    repeat (3) @(negedge sys_clk);
    check_val("rst_o", slot_o, 32'd0);
    check_val("rst_oe", slot_oe, 32'd0);
    check_val("rst_irq", {31'd0, irq}, 32'd0);
    sys_rst_n = 1'b1;
    repeat (8) @(negedge sys_clk);
    bus_rd(8'd6, rd);  check_val("arm_st0", {16'd0, rd}, 32'd0);
    bus_rd(8'd7, rd);  check_val("arm_st1", {16'd0, rd}, 32'd0);
    bus_rd(8'd16, rd); check_val("oob_rd", {16'd0, rd}, 32'd0);
    bus_wr(8'd20, 16'hFFFF);

    // Slot 1 OUT/DIR writes, visible one cycle after the strobe.
    bus_wr(8'd1, 16'hA5A5);
    check_val("o_s1", {16'd0, slot_o[31:16]}, 32'h0000A5A5);
    bus_wr(8'd5, 16'hFFFF);
    check_val("oe_s1", {16'd0, slot_oe[31:16]}, 32'h0000FFFF);
    check_val("o_s0", {16'd0, slot_o[15:0]}, 32'd0);
    check_val("oe_s0", {16'd0, slot_oe[15:0]}, 32'd0);
    bus_rd(8'd1, rd); check_val("rb_out1", {16'd0, rd}, 32'h0000A5A5);
    bus_rd(8'd5, rd); check_val("rb_dir1", {16'd0, rd}, 32'h0000FFFF);

    // IN path through the synchroniser.
    slot_i = 32'h0000_5555;
    repeat (3) @(negedge sys_clk);
    bus_rd(8'd2, rd); check_val("in_s0", {16'd0, rd}, 32'h00005555);

    // Rise/fall selection, sticky status, clear-by-one.
    slot_i[15:0] = 16'h0002;
    repeat (4) @(negedge sys_clk);
    bus_wr(8'd12, 16'h0001);
    bus_wr(8'd14, 16'h0002);
    bus_wr(8'd8, 16'hFFFF);
    bus_wr(8'd10, 16'hFFFF);
    bus_wr(8'd11, 16'hFFFF);
    slot_i[15:0] = 16'h0001;
    repeat (4) @(negedge sys_clk);
    bus_rd(8'd6, rd); check_val("st_both", {16'd0, rd}, 32'h00000003);
    check_val("irq_both", {31'd0, irq}, 32'd1);
    bus_wr(8'd10, 16'h0001);
    bus_rd(8'd6, rd); check_val("st_clr0", {16'd0, rd}, 32'h00000002);
    check_val("irq_clr0", {31'd0, irq}, 32'd1);
    bus_wr(8'd10, 16'h0002);
    @(negedge sys_clk);
    check_val("irq_clr1", {31'd0, irq}, 32'd0);

    // Masked edge still recorded; unmasking raises irq one cycle later.
    bus_wr(8'd8, 16'h0000);
    slot_i[15:0] = 16'h0000;
    repeat (4) @(negedge sys_clk);
    bus_wr(8'd10, 16'hFFFF);
    slot_i[15:0] = 16'h0001;
    repeat (4) @(negedge sys_clk);
    bus_rd(8'd6, rd); check_val("st_masked", {16'd0, rd}, 32'h00000001);
    check_val("irq_masked", {31'd0, irq}, 32'd0);
    bus_wr(8'd8, 16'h0001);
    check_val("irq_lat0", {31'd0, irq}, 32'd0);
    @(negedge sys_clk);
    check_val("irq_lat1", {31'd0, irq}, 32'd1);

    // Clear and qualifying edge in the same cycle: set wins.
    bus_wr(8'd8, 16'h0000);
    slot_i[15:0] = 16'h0000;
    repeat (4) @(negedge sys_clk);
    bus_wr(8'd10, 16'hFFFF);
    slot_i[15:0] = 16'h0001;
    @(negedge sys_clk);
    @(negedge sys_clk);
    bus_wr(8'd10, 16'h0001);
    bus_rd(8'd6, rd); check_val("set_wins", {16'd0, rd}, 32'h00000001);
    bus_wr(8'd10, 16'h0001);
    bus_rd(8'd6, rd); check_val("clr_after", {16'd0, rd}, 32'd0);

    // Randomised traffic and pad activity, checked by the model.
    for (int i = 0; i < 400; i++) begin
      bus_stb   = ($urandom_range(0, 2) == 0);
      bus_we    = 1'($urandom_range(0, 1));
      bus_addr  = 8'($urandom_range(0, 19));
      bus_wdata = 16'($urandom);
      if ($urandom_range(0, 3) == 0) slot_i = slot_i ^ NB'($urandom & $urandom);
      @(negedge sys_clk);
    end
    bus_stb = 1'b0;
    bus_we  = 1'b0;
    @(negedge sys_clk);

    // Reset mid-access aborts it; pads high across release stay quiet.
    slot_i    = {NB{1'b1}};
    bus_stb   = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = 8'd0;
    bus_wdata = 16'hFFFF;
    #2 sys_rst_n = 1'b0;
    @(negedge sys_clk);
    bus_stb = 1'b0;
    bus_we  = 1'b0;
    check_val("abort_ack", {31'd0, bus_ack}, 32'd0);
    check_val("abort_o", slot_o, 32'd0);
    check_val("abort_oe", slot_oe, 32'd0);
    check_val("abort_irq", {31'd0, irq}, 32'd0);
    check_val("abort_rdata", {16'd0, bus_rdata}, 32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (8) @(negedge sys_clk);
    bus_rd(8'd6, rd); check_val("rearm_st0", {16'd0, rd}, 32'd0);
    bus_rd(8'd7, rd); check_val("rearm_st1", {16'd0, rd}, 32'd0);
    bus_rd(8'd0, rd); check_val("abort_out", {16'd0, rd}, 32'd0);
    bus_rd(8'd12, rd); check_val("rst_rise", {16'd0, rd}, 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
